// File: rtl/vga_framebuffer_dbuf.sv
`default_nettype none
// ============================================================================
// Module  : vga_framebuffer_dbuf
// Purpose : Double-buffered colour VGA framebuffer with page swap and clear engine
// Rev     : 1.0  initial release
// ============================================================================
module vga_framebuffer_dbuf #(
    parameter int HACTIVE      = 640,
    parameter int HFRONT_PORCH = 16,
    parameter int HSYNC        = 96,
    parameter int HBACK_PORCH  = 48,
    parameter int VACTIVE      = 480,
    parameter int VFRONT_PORCH = 10,
    parameter int VSYNC        = 2,
    parameter int VBACK_PORCH  = 33,
    parameter int BPP          = 8
) (
    input  logic               clk50,
    input  logic               reset_n,
    input  logic signed [11:0] x,
    input  logic signed [11:0] y,
    input  logic [BPP-1:0]     pixel_color,
    input  logic               pixel_write,
    input  logic               swap_req,
    input  logic               clear_req,
    output logic               clear_busy,
    output logic               swap_pending,
    output logic               swap_done,
    output logic               front_sel,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic               VGA_CLK,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_n,
    output logic               VGA_SYNC_n
);

    localparam int c_h_pix  = HACTIVE + HFRONT_PORCH + HSYNC + HBACK_PORCH;
    localparam int c_htotal = 2 * c_h_pix;
    localparam int c_vtotal = VACTIVE + VFRONT_PORCH + VSYNC + VBACK_PORCH;
    localparam int c_depth  = HACTIVE * VACTIVE;
    localparam int c_hw     = $clog2(c_htotal);
    localparam int c_vw     = $clog2(c_vtotal);
    localparam int c_aw     = $clog2(2 * c_depth);

    localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_htotal - 1);
    localparam logic [c_hw-1:0] c_h_act2     = c_hw'(2 * HACTIVE);
    localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_vtotal - 1);
    localparam logic [c_vw-1:0] c_v_act      = c_vw'(VACTIVE);
    localparam logic [c_vw-1:0] c_v_act_last = c_vw'(VACTIVE - 1);
    localparam logic [31:0]     c_hs_lo      = 32'(2 * (HACTIVE + HFRONT_PORCH));
    localparam logic [31:0]     c_hs_hi      = 32'(2 * (HACTIVE + HFRONT_PORCH + HSYNC));
    localparam logic [31:0]     c_vs_lo      = 32'(VACTIVE + VFRONT_PORCH);
    localparam logic [31:0]     c_vs_hi      = 32'(VACTIVE + VFRONT_PORCH + VSYNC);
    localparam logic [11:0]     c_x_lim      = 12'(HACTIVE);
    localparam logic [11:0]     c_y_lim      = 12'(VACTIVE);
    localparam logic [c_aw-1:0] c_stride     = c_aw'(HACTIVE);
    localparam logic [c_aw-1:0] c_base1      = c_aw'(c_depth);
    localparam logic [c_aw-1:0] c_addr_last  = c_aw'(c_depth - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [c_hw-1:0] hcount_q, hcount_d;
    logic [c_vw-1:0] vcount_q, vcount_d;
    logic            front_sel_q, front_sel_d;
    logic            swap_pending_q, swap_pending_d;
    logic            swap_done_q, swap_done_d;
    logic            clear_busy_q, clear_busy_d;
    logic [c_aw-1:0] clear_addr_q, clear_addr_d;
    logic            clear_buf_q, clear_buf_d;
    logic [BPP-1:0]  clear_color_q, clear_color_d;
    logic            blank_n_q, blank_n_d;

    logic            w_eol;
    logic            w_active;
    logic            w_swap_pt;
    logic            w_swap_want;
    logic            w_in_range;
    logic [c_aw-1:0] w_host_addr;
    logic [c_aw-1:0] w_back_base;
    logic [c_aw-1:0] w_front_base;
    logic            w_we;
    logic [c_aw-1:0] w_waddr;
    logic [BPP-1:0]  w_wdata;
    logic            w_rd_en;
    logic [c_aw-1:0] w_raddr;
    logic            w_hs_n;
    logic            w_vs_n;
    logic [7:0]      w_r, w_g, w_b;

    logic [BPP-1:0]  mem [0:2*c_depth-1];
    logic [BPP-1:0]  pix_q;

    // ------------------------------------------------------------------
    // Raster counters and sync decode
    // ------------------------------------------------------------------
    always_comb begin
        w_eol    = (hcount_q == c_h_last);
        hcount_d = w_eol ? '0 : hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (w_eol) begin
            vcount_d = (vcount_q == c_v_last) ? '0 : vcount_q + 1'b1;
        end
        w_active = (hcount_q < c_h_act2) && (vcount_q < c_v_act);
        w_hs_n   = !((32'(hcount_q) >= c_hs_lo) && (32'(hcount_q) < c_hs_hi));
        w_vs_n   = !((32'(vcount_q) >= c_vs_lo) && (32'(vcount_q) < c_vs_hi));
    end

    // ------------------------------------------------------------------
    // Page swap: only at the end of the last visible line, never while clearing
    // ------------------------------------------------------------------
    always_comb begin
        w_swap_pt      = w_eol && (vcount_q == c_v_act_last);
        w_swap_want    = swap_pending_q | swap_req;
        front_sel_d    = front_sel_q;
        swap_pending_d = w_swap_want;
        swap_done_d    = 1'b0;
        if (w_swap_pt && w_swap_want && !clear_busy_q) begin
            front_sel_d    = ~front_sel_q;
            swap_pending_d = 1'b0;
            swap_done_d    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    always_comb begin
        clear_busy_d  = clear_busy_q;
        clear_addr_d  = clear_addr_q;
        clear_buf_d   = clear_buf_q;
        clear_color_d = clear_color_q;
        if (clear_busy_q) begin
            if (clear_addr_q == c_addr_last) begin
                clear_busy_d = 1'b0;
            end else begin
                clear_addr_d = clear_addr_q + 1'b1;
            end
        end else if (clear_req) begin
            clear_busy_d  = 1'b1;
            clear_addr_d  = '0;
            clear_buf_d   = ~front_sel_q;
            clear_color_d = pixel_color;
        end
    end

    // ------------------------------------------------------------------
    // Write port arbitration: the clear engine owns the port while busy
    // ------------------------------------------------------------------
    always_comb begin
        // Sign bit checked separately so negative coordinates never alias
        w_in_range   = !x[11] && ($unsigned(x) < c_x_lim) &&
                       !y[11] && ($unsigned(y) < c_y_lim);
        w_host_addr  = c_aw'(y[10:0]) * c_stride + c_aw'(x[10:0]);
        w_back_base  = front_sel_q ? '0 : c_base1;
        w_front_base = front_sel_q ? c_base1 : '0;
        w_we         = 1'b0;
        w_waddr      = (clear_buf_q ? c_base1 : '0) + clear_addr_q;
        w_wdata      = clear_color_q;
        if (clear_busy_q) begin
            w_we = 1'b1;
        end else if (pixel_write && w_in_range) begin
            w_we    = 1'b1;
            w_waddr = w_back_base + w_host_addr;
            w_wdata = pixel_color;
        end
    end

    // ------------------------------------------------------------------
    // Scan-out read, captured on odd half of each pixel period
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_en   = hcount_q[0] & w_active;
        w_raddr   = w_front_base + c_aw'(vcount_q) * c_stride + c_aw'(hcount_q >> 1);
        blank_n_d = hcount_q[0] ? w_active : blank_n_q;
    end

    always_ff @(posedge clk50) begin
        if (w_we) begin
            mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk50) begin
        if (w_rd_en) begin
            pix_q <= mem[w_raddr];
        end
    end

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            hcount_q       <= '0;
            vcount_q       <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            clear_busy_q   <= 1'b0;
            clear_addr_q   <= '0;
            clear_buf_q    <= 1'b0;
            clear_color_q  <= '0;
            blank_n_q      <= 1'b0;
        end else begin
            hcount_q       <= hcount_d;
            vcount_q       <= vcount_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
            clear_busy_q   <= clear_busy_d;
            clear_addr_q   <= clear_addr_d;
            clear_buf_q    <= clear_buf_d;
            clear_color_q  <= clear_color_d;
            blank_n_q      <= blank_n_d;
        end
    end

    // ------------------------------------------------------------------
    // Colour expansion to the 8-bit DAC channels
    // ------------------------------------------------------------------
    generate
        if (BPP == 1) begin : g_bpp1
            assign w_r = {8{pix_q[0]}};
            assign w_g = {8{pix_q[0]}};
            assign w_b = {8{pix_q[0]}};
        end else if (BPP == 3) begin : g_bpp3
            assign w_r = {8{pix_q[2]}};
            assign w_g = {8{pix_q[1]}};
            assign w_b = {8{pix_q[0]}};
        end else if (BPP == 8) begin : g_bpp8
            assign w_r = {pix_q[7:5], pix_q[7:5], pix_q[7:6]};
            assign w_g = {pix_q[4:2], pix_q[4:2], pix_q[4:3]};
            assign w_b = {4{pix_q[1:0]}};
        end else begin : g_bpp_bad
            $error("vga_framebuffer_dbuf: BPP must be 1, 3 or 8");
            assign w_r = '0;
            assign w_g = '0;
            assign w_b = '0;
        end
    endgenerate

    assign VGA_R        = blank_n_q ? w_r : 8'h00;
    assign VGA_G        = blank_n_q ? w_g : 8'h00;
    assign VGA_B        = blank_n_q ? w_b : 8'h00;
    assign VGA_CLK      = hcount_q[0];
    assign VGA_HS       = w_hs_n;
    assign VGA_VS       = w_vs_n;
    assign VGA_BLANK_n  = blank_n_q;
    assign VGA_SYNC_n   = 1'b1;
    assign clear_busy   = clear_busy_q;
    assign swap_pending = swap_pending_q;
    assign swap_done    = swap_done_q;
    assign front_sel    = front_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_framebuffer_dbuf.sv
`default_nettype none
// Bench for vga_framebuffer_dbuf: reduced raster, three colour depths sharing one stimulus,
// outputs compared every cycle with a frame-position reference model.
module tb_vga_framebuffer_dbuf;

    localparam int HA = 16, HF = 2, HSY = 4, HB = 2;
    localparam int VA = 8, VF = 1, VSY = 2, VB = 2;
    localparam int LINE     = 2 * (HA + HF + HSY + HB);
    localparam int VT       = VA + VF + VSY + VB;
    localparam int FRAME    = LINE * VT;
    localparam int DEPTH    = HA * VA;
    localparam int SWAP_POS = LINE * (VA - 1) + LINE - 1;

    logic              clk50 = 1'b0;
    logic              reset_n;
    logic signed [11:0] x, y;
    logic [7:0]        pixel_color;
    logic              pixel_write, swap_req, clear_req;

    logic       clear_busy, swap_pending, swap_done, front_sel;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;

    logic       b1_busy, b1_pend, b1_done, b1_front, b1_clk, b1_hs, b1_vs, b1_blank, b1_sync;
    logic [7:0] b1_r, b1_g, b1_b;
    logic       b3_busy, b3_pend, b3_done, b3_front, b3_clk, b3_hs, b3_vs, b3_blank, b3_sync;
    logic [7:0] b3_r, b3_g, b3_b;

    always #10 clk50 = ~clk50;

    vga_framebuffer_dbuf #(
        .HACTIVE(HA), .HFRONT_PORCH(HF), .HSYNC(HSY), .HBACK_PORCH(HB),
        .VACTIVE(VA), .VFRONT_PORCH(VF), .VSYNC(VSY), .VBACK_PORCH(VB), .BPP(8)
    ) u_dut8 (
        .clk50(clk50), .reset_n(reset_n), .x(x), .y(y), .pixel_color(pixel_color),
        .pixel_write(pixel_write), .swap_req(swap_req), .clear_req(clear_req),
        .clear_busy(clear_busy), .swap_pending(swap_pending), .swap_done(swap_done),
        .front_sel(front_sel), .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
        .VGA_CLK(vga_clk), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
        .VGA_BLANK_n(vga_blank_n), .VGA_SYNC_n(vga_sync_n)
    );

    vga_framebuffer_dbuf #(
        .HACTIVE(HA), .HFRONT_PORCH(HF), .HSYNC(HSY), .HBACK_PORCH(HB),
        .VACTIVE(VA), .VFRONT_PORCH(VF), .VSYNC(VSY), .VBACK_PORCH(VB), .BPP(1)
    ) u_dut1 (
        .clk50(clk50), .reset_n(reset_n), .x(x), .y(y), .pixel_color(pixel_color[0:0]),
        .pixel_write(pixel_write), .swap_req(swap_req), .clear_req(clear_req),
        .clear_busy(b1_busy), .swap_pending(b1_pend), .swap_done(b1_done),
        .front_sel(b1_front), .VGA_R(b1_r), .VGA_G(b1_g), .VGA_B(b1_b),
        .VGA_CLK(b1_clk), .VGA_HS(b1_hs), .VGA_VS(b1_vs),
        .VGA_BLANK_n(b1_blank), .VGA_SYNC_n(b1_sync)
    );

    vga_framebuffer_dbuf #(
        .HACTIVE(HA), .HFRONT_PORCH(HF), .HSYNC(HSY), .HBACK_PORCH(HB),
        .VACTIVE(VA), .VFRONT_PORCH(VF), .VSYNC(VSY), .VBACK_PORCH(VB), .BPP(3)
    ) u_dut3 (
        .clk50(clk50), .reset_n(reset_n), .x(x), .y(y), .pixel_color(pixel_color[2:0]),
        .pixel_write(pixel_write), .swap_req(swap_req), .clear_req(clear_req),
        .clear_busy(b3_busy), .swap_pending(b3_pend), .swap_done(b3_done),
        .front_sel(b3_front), .VGA_R(b3_r), .VGA_G(b3_g), .VGA_B(b3_b),
        .VGA_CLK(b3_clk), .VGA_HS(b3_hs), .VGA_VS(b3_vs),
        .VGA_BLANK_n(b3_blank), .VGA_SYNC_n(b3_sync)
    );

    // Reference model state
    int         t;
    bit         ref_front, ref_pend, ref_done;
    int         ref_left;
    logic [7:0] ref_mem   [2][DEPTH];
    bit         ref_known [2][DEPTH];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [23:0] rgb8(input logic [7:0] c);
        int r, g, b;
        r = (int'(c[7:5]) * 73) >> 1;
        g = (int'(c[4:2]) * 73) >> 1;
        b = int'(c[1:0]) * 85;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    function automatic logic [23:0] rgb3(input logic [7:0] c);
        return {(c[2] ? 8'hFF : 8'h00), (c[1] ? 8'hFF : 8'h00), (c[0] ? 8'hFF : 8'h00)};
    endfunction

    function automatic logic [23:0] rgb1(input logic [7:0] c);
        return c[0] ? 24'hFFFFFF : 24'h000000;
    endfunction

    // Apply the inputs present during cycle t to the model
    task automatic model_step();
        int h, v, xi, yi, bk;
        bit busy, want;
        h    = t % LINE;
        v    = (t / LINE) % VT;
        busy = (ref_left > 0);
        bk   = ref_front ? 0 : 1;
        xi   = int'(x);
        yi   = int'(y);
        if (pixel_write && !busy && xi >= 0 && xi < HA && yi >= 0 && yi < VA) begin
            ref_mem[bk][yi * HA + xi]   = pixel_color;
            ref_known[bk][yi * HA + xi] = 1'b1;
        end
        if (busy) begin
            ref_left--;
        end else if (clear_req) begin
            ref_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[bk][i]   = pixel_color;
                ref_known[bk][i] = 1'b1;
            end
        end
        want     = ref_pend | swap_req;
        ref_done = 1'b0;
        if (h == LINE - 1 && v == VA - 1 && want && !busy) begin
            ref_front = !ref_front;
            ref_pend  = 1'b0;
            ref_done  = 1'b1;
        end else begin
            ref_pend = want;
        end
    endtask

    task automatic check_all();
        int h, v, k, hk, vk, idx, fb;
        bit act;
        logic [7:0] c;
        h = t % LINE;
        v = (t / LINE) % VT;
        check("hsync", vga_hs, !(h >= 2 * (HA + HF) && h < 2 * (HA + HF + HSY)));
        check("vsync", vga_vs, !(v >= VA + VF && v < VA + VF + VSY));
        check("vga_clk", vga_clk, h % 2);
        check("sync_n", vga_sync_n, 1);
        check("clear_busy", clear_busy, ref_left > 0);
        check("swap_pending", swap_pending, ref_pend);
        check("swap_done", swap_done, ref_done);
        check("front_sel", front_sel, ref_front);
        // Pixel on the DAC was fetched at the latest odd raster position before t
        k   = ((t - 1) % 2 == 1) ? t - 1 : t - 2;
        hk  = (k >= 0) ? k % LINE : 0;
        vk  = (k >= 0) ? (k / LINE) % VT : 0;
        act = (k >= 0) && (hk < 2 * HA) && (vk < VA);
        check("blank_n", vga_blank_n, act);
        if (!act) begin
            check("rgb8_blank", {vga_r, vga_g, vga_b}, 0);
            check("rgb1_blank", {b1_r, b1_g, b1_b}, 0);
            check("rgb3_blank", {b3_r, b3_g, b3_b}, 0);
        end else begin
            fb  = ref_front ? 1 : 0;
            idx = vk * HA + hk / 2;
            if (ref_known[fb][idx]) begin
                c = ref_mem[fb][idx];
                check("rgb8_pixel", {vga_r, vga_g, vga_b}, rgb8(c));
                check("rgb1_pixel", {b1_r, b1_g, b1_b}, rgb1(c));
                check("rgb3_pixel", {b3_r, b3_g, b3_b}, rgb3(c));
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk50);
        #1;
        t++;
        check_all();
        pixel_write = 1'b0;
        swap_req    = 1'b0;
        clear_req   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) tick();
    endtask

    task automatic write_px(input int xi, input int yi, input logic [7:0] c);
        x = 12'(xi);
        y = 12'(yi);
        pixel_color = c;
        pixel_write = 1'b1;
        tick();
    endtask

    task automatic rand_write();
        x = 12'(int'($urandom_range(HA + 3)) - 2);
        y = 12'(int'($urandom_range(VA + 3)) - 2);
        pixel_color = 8'($urandom);
        pixel_write = 1'b1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk50);
            #1;
            check("rst_hs", vga_hs, 1);
            check("rst_vs", vga_vs, 1);
            check("rst_clk", vga_clk, 0);
            check("rst_blank_n", vga_blank_n, 0);
            check("rst_rgb8", {vga_r, vga_g, vga_b}, 0);
            check("rst_rgb1", {b1_r, b1_g, b1_b}, 0);
            check("rst_rgb3", {b3_r, b3_g, b3_b}, 0);
            check("rst_busy", clear_busy, 0);
            check("rst_pending", swap_pending, 0);
            check("rst_done", swap_done, 0);
            check("rst_front", front_sel, 0);
        end
        reset_n   = 1'b1;
        t         = 0;
        ref_front = 1'b0;
        ref_pend  = 1'b0;
        ref_done  = 1'b0;
        ref_left  = 0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < DEPTH; i++) ref_known[b][i] = 1'b0;
        pixel_write = 1'b0;
        swap_req    = 1'b0;
        clear_req   = 1'b0;
    endtask

    initial begin
        int hs_low, blank_hi, vs_low;
        x = '0; y = '0; pixel_color = '0;
        pixel_write = 1'b0; swap_req = 1'b0; clear_req = 1'b0;
        reset_n = 1'b0;
        do_reset(3);

        // Raster timing over one line and one frame
        idle(FRAME - 1);
        run_to(0);
        hs_low = 0; blank_hi = 0; vs_low = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (i < LINE) begin
                hs_low   += int'(!vga_hs);
                blank_hi += int'(vga_blank_n);
            end
            vs_low += int'(!vga_vs);
        end
        check("hs_low_per_line", hs_low, 2 * HSY);
        check("blank_high_line0", blank_hi, 2 * HA);
        check("vs_low_per_frame", vs_low, VSY * LINE);

        // Clear back buffer to black; writes and clear requests during busy are dropped
        pixel_color = 8'h00;
        clear_req = 1'b1;
        tick();
        for (int i = 0; i < DEPTH + 4; i++) begin
            rand_write();
            if (i % 37 == 5) clear_req = 1'b1;
            tick();
        end
        write_px(5, 3, 8'hE0);
        write_px(6, 3, 8'hE5);
        write_px(4, 3, 8'h00);
        swap_req = 1'b1;
        tick();
        run_to(SWAP_POS);
        tick();
        check("front_after_swap", front_sel, 1);
        idle(FRAME);

        // Clear other buffer to blue, then boundary and out-of-range writes
        pixel_color = 8'h03;
        clear_req = 1'b1;
        tick();
        idle(DEPTH + 2);
        write_px(-1, 1, 8'hFF);
        write_px(HA, 0, 8'hFF);
        write_px(0, VA, 8'hFF);
        write_px(0, -2, 8'hFF);
        write_px(HA + 1, VA - 1, 8'hFF);
        write_px(HA - 1, VA - 1, 8'hA5);
        swap_req = 1'b1;
        tick();
        run_to(SWAP_POS);
        tick();
        idle(FRAME);

        // Swap requested while a clear spans the frame end
        run_to(SWAP_POS - 20);
        pixel_color = 8'($urandom);
        clear_req = 1'b1;
        tick();
        swap_req = 1'b1;
        tick();
        idle(2 * FRAME);

        // Random traffic
        for (int i = 0; i < 4 * FRAME; i++) begin
            if ($urandom_range(1) == 1) rand_write();
            if ($urandom_range(199) == 0) swap_req = 1'b1;
            if ($urandom_range(299) == 0) begin
                clear_req   = 1'b1;
                pixel_color = 8'($urandom);
            end
            tick();
        end

        // Reset in the middle of a clear and a frame
        pixel_color = 8'($urandom);
        clear_req = 1'b1;
        tick();
        idle(40 + int'($urandom_range(30)));
        do_reset(1);
        idle(FRAME / 2);
        pixel_color = 8'h1C;
        clear_req = 1'b1;
        tick();
        swap_req = 1'b1;
        tick();
        idle(2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
